// File: rtl/mul8s_err_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul8s_err_pkg
//  Description : Shared widths, window state encoding and the saturating
//                adder used by the mul8s error meter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul8s_err_pkg;

    localparam int OP_W   = 8;          // operand width
    localparam int PROD_W = 16;         // exact / approximate product width
    localparam int ERR_W  = 17;         // signed error and |e| width
    localparam int SQ_W   = 2 * ERR_W;  // |e|*|e| width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } err_state_e;

    // Add inc to acc and clamp the result to lim; both accumulators in the
    // meter are at most 64 bits wide, so a 65-bit internal sum is exact.
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input logic [63:0] lim);
        logic [64:0] s;
        s = {1'b0, acc} + {1'b0, inc};
        return (s > {1'b0, lim}) ? lim : s[63:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul8s_err_calc.sv
`default_nettype none
// ============================================================================
//  Module      : mul8s_err_calc
//  Description : Error stage 1. Forms the exact signed product of the aligned
//                operands, the signed error against the approximate product
//                and its magnitude, all registered. With MUL8S_ERR_SQ_EN
//                defined it also registers |e|*|e|.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul8s_err_calc
    import mul8s_err_pkg::*;
(
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic              i_flush,    // drop the sample being captured
    input  logic              i_valid,
    input  logic [OP_W-1:0]   i_a,
    input  logic [OP_W-1:0]   i_b,
    input  logic [PROD_W-1:0] i_o,
    output logic              o_valid,
    output logic [OP_W-1:0]   o_a,
    output logic [OP_W-1:0]   o_b,
    output logic [ERR_W-1:0]  o_abs
`ifdef MUL8S_ERR_SQ_EN
    ,
    output logic [SQ_W-1:0]   o_sq
`endif
);

    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_p;
    logic [ERR_W-1:0]  w_e;
    logic [ERR_W-1:0]  w_abs;

    // Sign-extend to the product width so the 16-bit product is exact.
    assign w_a_ext = {{(PROD_W-OP_W){i_a[OP_W-1]}}, i_a};
    assign w_b_ext = {{(PROD_W-OP_W){i_b[OP_W-1]}}, i_b};
    assign w_p     = PROD_W'($signed(w_a_ext) * $signed(w_b_ext));
    assign w_e     = {i_o[PROD_W-1], i_o} - {w_p[PROD_W-1], w_p};
    assign w_abs   = w_e[ERR_W-1] ? (~w_e + ERR_W'(1)) : w_e;

    // Register the error terms; a flush only kills the valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid <= 1'b0;
            o_a     <= '0;
            o_b     <= '0;
            o_abs   <= '0;
        end else begin
            o_valid <= i_valid && !i_flush;
            o_a     <= i_a;
            o_b     <= i_b;
            o_abs   <= w_abs;
        end
    end

`ifdef MUL8S_ERR_SQ_EN
    // Registered squarer; e*e equals |e|*|e|, so the unsigned form suffices.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_sq <= '0;
        end else begin
            o_sq <= {{(SQ_W-ERR_W){1'b0}}, w_abs} * {{(SQ_W-ERR_W){1'b0}}, w_abs};
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mul8s_err_meter.sv
`default_nettype none
// ============================================================================
//  Module      : mul8s_err_meter
//  Description : Windowed error statistics for the mul8s approximate
//                multiplier: operand alignment, stage-1 error calculation,
//                window FSM and saturating accumulators.
//                Optional macro MUL8S_ERR_SQ_EN adds the sum_sq output.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul8s_err_meter
    import mul8s_err_pkg::*;
#(
    parameter int DUT_LAT = 1,   // multiplier latency, 0..4
    parameter int WIN_W   = 16,
    parameter int SUM_W   = 32   // >= 17, <= 32
) (
    input  logic                 clk,
    input  logic                 rst,       // asynchronous, active-low
    input  logic                 in_valid,
    input  logic [OP_W-1:0]      A,
    input  logic [OP_W-1:0]      B,
    input  logic [PROD_W-1:0]    O,
    input  logic                 start,
    input  logic                 clear,
    input  logic [WIN_W-1:0]     cfg_len,
    output logic                 busy,
    output logic                 done,
    output logic [WIN_W-1:0]     smp_cnt,
    output logic [WIN_W-1:0]     err_cnt,
    output logic [SUM_W-1:0]     sum_abs,
`ifdef MUL8S_ERR_SQ_EN
    output logic [2*SUM_W-1:0]   sum_sq,
`endif
    output logic                 sum_sat,
    output logic [ERR_W-1:0]     max_abs,
    output logic [OP_W-1:0]      worst_a,
    output logic [OP_W-1:0]      worst_b
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic              w_al_v;
    logic [OP_W-1:0]   w_al_a;
    logic [OP_W-1:0]   w_al_b;
    logic              w_s1_valid;
    logic [OP_W-1:0]   w_s1_a;
    logic [OP_W-1:0]   w_s1_b;
    logic [ERR_W-1:0]  w_s1_abs;
    logic              w_start_ok;
    logic              w_accept;
    logic              w_last;
    logic              w_abs_ovf;

    logic [1:0]        r_state;
    logic [WIN_W-1:0]  r_len;
    logic [WIN_W-1:0]  r_smp;
    logic [WIN_W-1:0]  r_err;
    logic [SUM_W-1:0]  r_sum_abs;
    logic              r_sum_sat;
    logic [ERR_W-1:0]  r_max;
    logic [OP_W-1:0]   r_worst_a;
    logic [OP_W-1:0]   r_worst_b;

    // Delay valid/A/B by DUT_LAT so they meet the matching O.
    generate
        if (DUT_LAT == 0) begin : g_align_none
            assign w_al_v = in_valid;
            assign w_al_a = A;
            assign w_al_b = B;
        end else begin : g_align_pipe
            logic            r_v [DUT_LAT];
            logic [OP_W-1:0] r_a [DUT_LAT];
            logic [OP_W-1:0] r_b [DUT_LAT];

            // Free-running shift register; never stalls.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DUT_LAT; i++) begin
                        r_v[i] <= 1'b0;
                        r_a[i] <= '0;
                        r_b[i] <= '0;
                    end
                end else begin
                    r_v[0] <= in_valid;
                    r_a[0] <= A;
                    r_b[0] <= B;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        r_v[i] <= r_v[i-1];
                        r_a[i] <= r_a[i-1];
                        r_b[i] <= r_b[i-1];
                    end
                end
            end

            assign w_al_v = r_v[DUT_LAT-1];
            assign w_al_a = r_a[DUT_LAT-1];
            assign w_al_b = r_b[DUT_LAT-1];
        end
    endgenerate

    // A window opens from IDLE or DONE only, and never with a zero length.
    assign w_start_ok = start && (cfg_len != '0) && (r_state != S_RUN);
    assign w_accept   = w_s1_valid && (r_state == S_RUN) && (r_smp < r_len);
    assign w_last     = w_accept && ((r_smp + WIN_W'(1)) == r_len);
    assign w_abs_ovf  = ({1'b0, r_sum_abs} + (SUM_W+1)'(w_s1_abs)) >
                        (SUM_W+1)'({SUM_W{1'b1}});

`ifdef MUL8S_ERR_SQ_EN
    logic [SQ_W-1:0]    w_s1_sq;
    logic [2*SUM_W-1:0] r_sum_sq;
`endif

    // Opening a window flushes stage 1 so pre-window samples never count.
    mul8s_err_calc u_calc (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_start_ok),
        .i_valid (w_al_v),
        .i_a     (w_al_a),
        .i_b     (w_al_b),
        .i_o     (O),
        .o_valid (w_s1_valid),
        .o_a     (w_s1_a),
        .o_b     (w_s1_b),
        .o_abs   (w_s1_abs)
`ifdef MUL8S_ERR_SQ_EN
        ,
        .o_sq    (w_s1_sq)
`endif
    );

    // Window FSM: clear wins over start; the last commit ends the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
        end else if (clear) begin
            r_state <= S_IDLE;
        end else if (w_start_ok) begin
            r_state <= S_RUN;
            r_len   <= cfg_len;
        end else if (w_last) begin
            r_state <= S_DONE;
        end
    end

    // Stage 2: zero on clear/window open, otherwise fold in accepted samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_smp     <= '0;
            r_err     <= '0;
            r_sum_abs <= '0;
            r_sum_sat <= 1'b0;
            r_max     <= '0;
            r_worst_a <= '0;
            r_worst_b <= '0;
        end else if (clear || w_start_ok) begin
            r_smp     <= '0;
            r_err     <= '0;
            r_sum_abs <= '0;
            r_sum_sat <= 1'b0;
            r_max     <= '0;
            r_worst_a <= '0;
            r_worst_b <= '0;
        end else if (w_accept) begin
            r_smp     <= r_smp + WIN_W'(1);
            if (w_s1_abs != '0) begin
                r_err <= r_err + WIN_W'(1);
            end
            r_sum_abs <= SUM_W'(sat_add(64'(r_sum_abs), 64'(w_s1_abs),
                                        64'({SUM_W{1'b1}})));
            if (w_abs_ovf) begin
                r_sum_sat <= 1'b1;
            end
            // Strict compare: on a tie the earliest sample is kept.
            if (w_s1_abs > r_max) begin
                r_max     <= w_s1_abs;
                r_worst_a <= w_s1_a;
                r_worst_b <= w_s1_b;
            end
        end
    end

`ifdef MUL8S_ERR_SQ_EN
    // Saturating sum of squared errors, cleared alongside the other stats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum_sq <= '0;
        end else if (clear || w_start_ok) begin
            r_sum_sq <= '0;
        end else if (w_accept) begin
            r_sum_sq <= (2*SUM_W)'(sat_add(64'(r_sum_sq), 64'(w_s1_sq),
                                           64'({(2*SUM_W){1'b1}})));
        end
    end

    assign sum_sq = r_sum_sq;
`endif

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign smp_cnt = r_smp;
    assign err_cnt = r_err;
    assign sum_abs = r_sum_abs;
    assign sum_sat = r_sum_sat;
    assign max_abs = r_max;
    assign worst_a = r_worst_a;
    assign worst_b = r_worst_b;

endmodule
`default_nettype wire
